// File: rtl/reg_file_mp.sv
// reg_file_mp: register file for a 16-bit-class CPU core.
// R0 = PC, R1 = SP, R2 = SR / constant generator 1, R3 = constant generator 2,
// and the remaining registers are general purpose. Two write ports (A has
// priority), PC auto-increment, masked flag update and two combinational
// read ports with optional write-through forwarding.
module reg_file_mp #(
    parameter int DW     = 16,
    parameter int NREG   = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DW-1:0]            rst_vec,
    input  logic                     we_a,
    input  logic [$clog2(NREG)-1:0]  da_a,
    input  logic [DW-1:0]            din_a,
    input  logic                     we_b,
    input  logic [$clog2(NREG)-1:0]  da_b,
    input  logic [DW-1:0]            din_b,
    input  logic                     pc_inc,
    input  logic                     sr_we,
    input  logic [DW-1:0]            sr_mask,
    input  logic [DW-1:0]            sr_in,
    input  logic [$clog2(NREG)-1:0]  sa0,
    input  logic [1:0]               as0,
    input  logic [$clog2(NREG)-1:0]  sa1,
    input  logic [1:0]               as1,
    output logic [DW-1:0]            rd0,
    output logic [DW-1:0]            rd1,
    output logic [DW-1:0]            pc_out,
    output logic [DW-1:0]            sp_out,
    output logic [DW-1:0]            sr_out,
    output logic                     pc_fault
);

    localparam int AW = $clog2(NREG);

    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] regs_d [NREG];
    logic          pc_fault_q;
    logic          pc_fault_d;
    logic          hit_a;
    logic          hit_b;
    logic [DW-1:0] wr_val;
    logic [DW-1:0] src0;
    logic [DW-1:0] src1;

    // Constant generator on R2/R3; every other address passes the register value.
    function automatic logic [DW-1:0] read_mux(input logic [AW-1:0] sa,
                                               input logic [1:0]    as,
                                               input logic [DW-1:0] val);
        logic [DW-1:0] res;
        res = val;
        if (sa == AW'(2)) begin
            case (as)
                2'b00:   res = val;
                2'b01:   res = '0;
                2'b10:   res = DW'(4);
                default: res = DW'(8);
            endcase
        end else if (sa == AW'(3)) begin
            case (as)
                2'b00:   res = '0;
                2'b01:   res = DW'(1);
                2'b10:   res = DW'(2);
                default: res = '1;
            endcase
        end
        return res;
    endfunction

    // Next-state of every register: reset, then A > B > sr_we > pc_inc > hold.
    always_comb begin
        regs_d     = regs_q;
        pc_fault_d = 1'b0;
        hit_a      = 1'b0;
        hit_b      = 1'b0;
        wr_val     = '0;
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_d[i] = '0;
            end
            regs_d[0] = {rst_vec[DW-1:1], 1'b0};
        end else begin
            for (int i = 0; i < NREG; i++) begin
                hit_a  = we_a && (da_a == AW'(i));
                hit_b  = we_b && (da_b == AW'(i));
                wr_val = hit_a ? din_a : din_b;
                if (i == 3) begin
                    // R3 has no real storage; it only backs the constant generator.
                    regs_d[i] = '0;
                end else if (hit_a || hit_b) begin
                    if (i == 0) begin
                        // An odd PC is refused outright; the increment is lost too.
                        if (wr_val[0]) begin
                            pc_fault_d = 1'b1;
                        end else begin
                            regs_d[i] = wr_val;
                        end
                    end else if (i == 1) begin
                        regs_d[i] = {wr_val[DW-1:1], 1'b0};
                    end else begin
                        regs_d[i] = wr_val;
                    end
                end else if ((i == 2) && sr_we) begin
                    regs_d[i] = (regs_q[2] & ~sr_mask) | (sr_in & sr_mask);
                end else if ((i == 0) && pc_inc) begin
                    regs_d[i] = regs_q[0] + DW'(2);
                end
            end
        end
    end

    // Register storage and the fault pulse flop.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
        end
        pc_fault_q <= pc_fault_d;
    end

    // Read ports: forward the post-edge value when BYPASS is set.
    always_comb begin
        src0 = BYPASS ? regs_d[sa0] : regs_q[sa0];
        src1 = BYPASS ? regs_d[sa1] : regs_q[sa1];
        rd0  = read_mux(sa0, as0, src0);
        rd1  = read_mux(sa1, as1, src1);
    end

    assign pc_out   = regs_q[0];
    assign sp_out   = regs_q[1];
    assign sr_out   = regs_q[2];
    assign pc_fault = pc_fault_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Testbench for reg_file_mp (DW=16, NREG=16, BYPASS=1).
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] rst_vec;
    logic        we_a, we_b, pc_inc, sr_we;
    logic [3:0]  da_a, da_b, sa0, sa1;
    logic [15:0] din_a, din_b, sr_mask, sr_in;
    logic [1:0]  as0, as1;
    logic [15:0] rd0, rd1, pc_out, sp_out, sr_out;
    logic        pc_fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst;
        logic        we_a;  logic [3:0] da_a;  logic [15:0] din_a;
        logic        we_b;  logic [3:0] da_b;  logic [15:0] din_b;
        logic        pc_inc;
        logic        sr_we; logic [15:0] sr_mask; logic [15:0] sr_in;
        logic [3:0]  sa0;   logic [1:0] as0;
        logic [3:0]  sa1;   logic [1:0] as1;
        logic [15:0] e_rd0; logic [15:0] e_rd1;
        logic [15:0] e_pc;  logic [15:0] e_sp; logic [15:0] e_sr;
        logic        e_f;
    } vec_t;

    vec_t vecs [20];
    vec_t seq  [4];
    vec_t sb   [$];

    reg_file_mp #(.DW(16), .NREG(16), .BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .rst_vec(rst_vec),
        .we_a(we_a), .da_a(da_a), .din_a(din_a),
        .we_b(we_b), .da_b(da_b), .din_b(din_b),
        .pc_inc(pc_inc), .sr_we(sr_we), .sr_mask(sr_mask), .sr_in(sr_in),
        .sa0(sa0), .as0(as0), .sa1(sa1), .as1(as1),
        .rd0(rd0), .rd1(rd1), .pc_out(pc_out), .sp_out(sp_out), .sr_out(sr_out),
        .pc_fault(pc_fault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t, input int idx);
        vec_t e;
        @(negedge clk);
        rst = t.rst;
        we_a = t.we_a; da_a = t.da_a; din_a = t.din_a;
        we_b = t.we_b; da_b = t.da_b; din_b = t.din_b;
        pc_inc = t.pc_inc;
        sr_we = t.sr_we; sr_mask = t.sr_mask; sr_in = t.sr_in;
        sa0 = t.sa0; as0 = t.as0; sa1 = t.sa1; as1 = t.as1;
        sb.push_back(t);
        #1;
        check($sformatf("rd0[%0d]", idx), rd0, t.e_rd0);
        check($sformatf("rd1[%0d]", idx), rd1, t.e_rd1);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard[%0d]: queue empty, expected 1 entry", idx);
        end else begin
            e = sb.pop_front();
            check($sformatf("pc_out[%0d]", idx), pc_out, e.e_pc);
            check($sformatf("sp_out[%0d]", idx), sp_out, e.e_sp);
            check($sformatf("sr_out[%0d]", idx), sr_out, e.e_sr);
            check($sformatf("pc_fault[%0d]", idx), {15'd0, pc_fault}, {15'd0, e.e_f});
        end
    endtask

    initial begin
        rst = 1'b1; rst_vec = 16'hC000;
        we_a = 0; da_a = 0; din_a = 0; we_b = 0; da_b = 0; din_b = 0;
        pc_inc = 0; sr_we = 0; sr_mask = 0; sr_in = 0;
        sa0 = 0; as0 = 0; sa1 = 0; as1 = 0;

        //          rst we_a da_a din_a    we_b da_b din_b    inc swe mask     in       sa0 as0 sa1 as1 rd0      rd1      pc       sp       sr       f
        // reset with in-flight writes; constants still readable during reset
        vecs[0]  = '{1, 1, 6, 16'hAAAA, 0, 0, 16'h0000, 1, 1, 16'hFFFF, 16'h1234, 3, 3, 2, 1, 16'hFFFF, 16'h0000, 16'hC000, 16'h0000, 16'h0000, 0};
        // pc_inc x3 with constant reads
        vecs[1]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 3, 3, 16'hC002, 16'hFFFF, 16'hC002, 16'h0000, 16'h0000, 0};
        vecs[2]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 2, 2, 16'hC004, 16'h0004, 16'hC004, 16'h0000, 16'h0000, 0};
        vecs[3]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 2, 1, 2, 3, 16'h0000, 16'h0008, 16'hC006, 16'h0000, 16'h0000, 0};
        // same-address collision: A wins, bypass shows A
        vecs[4]  = '{0, 1, 5, 16'h1234, 1, 5, 16'hBEEF, 0, 0, 16'h0000, 16'h0000, 5, 0, 3, 0, 16'h1234, 16'h0000, 16'hC006, 16'h0000, 16'h0000, 0};
        vecs[5]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 5, 2, 3, 1, 16'h1234, 16'h0001, 16'hC006, 16'h0000, 16'h0000, 0};
        // R3 write ignored
        vecs[6]  = '{0, 1, 3, 16'h5555, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3, 0, 3, 2, 16'h0000, 16'h0002, 16'hC006, 16'h0000, 16'h0000, 0};
        vecs[7]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 3, 0, 4, 0, 16'h0000, 16'h0000, 16'hC006, 16'h0000, 16'h0000, 0};
        // SR: direct write, masked update, port beats sr_we
        vecs[8]  = '{0, 1, 2, 16'h00F0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 2, 0, 5, 0, 16'h00F0, 16'h1234, 16'hC006, 16'h0000, 16'h00F0, 0};
        vecs[9]  = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h000F, 16'h0005, 2, 0, 2, 1, 16'h00F5, 16'h0000, 16'hC006, 16'h0000, 16'h00F5, 0};
        vecs[10] = '{0, 1, 2, 16'h0100, 0, 0, 16'h0000, 0, 1, 16'hFFFF, 16'hFFFF, 2, 0, 0, 0, 16'h0100, 16'hC006, 16'hC006, 16'h0000, 16'h0100, 0};
        // odd PC write rejected with pc_inc suppressed, then fault clears
        vecs[11] = '{0, 1, 0, 16'hC101, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 5, 0, 16'hC006, 16'h1234, 16'hC006, 16'h0000, 16'h0100, 1};
        vecs[12] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 2, 0, 16'hC006, 16'h0100, 16'hC006, 16'h0000, 16'h0100, 0};
        // SP bit 0 cleared; A beats B on SP
        vecs[13] = '{0, 0, 0, 16'h0000, 1, 1, 16'h0281, 0, 0, 16'h0000, 16'h0000, 1, 0, 3, 3, 16'h0280, 16'hFFFF, 16'hC006, 16'h0280, 16'h0100, 0};
        vecs[14] = '{0, 1, 1, 16'h1235, 1, 1, 16'h4444, 0, 0, 16'h0000, 16'h0000, 3, 3, 1, 0, 16'hFFFF, 16'h1234, 16'hC006, 16'h1234, 16'h0100, 0};
        // port write beats pc_inc; then wrap 0xFFFE -> 0x0000
        vecs[15] = '{0, 0, 0, 16'h0000, 1, 0, 16'hFFFE, 1, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 16'hFFFE, 16'h1234, 16'hFFFE, 16'h1234, 16'h0100, 0};
        vecs[16] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h0100, 0};
        // odd PC via port B also rejected
        vecs[17] = '{0, 0, 0, 16'h0000, 1, 0, 16'h0011, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h0100, 1};
        // independent writes on both ports, independent reads
        vecs[18] = '{0, 1, 7, 16'hA5A5, 1, 8, 16'h5A5A, 0, 0, 16'h0000, 16'h0000, 7, 0, 8, 0, 16'hA5A5, 16'h5A5A, 16'h0000, 16'h1234, 16'h0100, 0};
        vecs[19] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 8, 3, 7, 2, 16'h5A5A, 16'hA5A5, 16'h0000, 16'h1234, 16'h0100, 0};

        for (int i = 0; i < 20; i++) begin
            apply(vecs[i], i);
        end

        // Hand sequence: reset dominates in-flight writes, odd vector bit 0 cleared,
        // first write after reset accepted immediately.
        seq[0] = '{0, 1, 4, 16'h9999, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 4, 0, 6, 0, 16'h9999, 16'h0000, 16'h0000, 16'h1234, 16'h0100, 0};
        seq[1] = '{1, 1, 6, 16'hABCD, 1, 0, 16'h0003, 1, 1, 16'hFFFF, 16'hFFFF, 3, 0, 3, 3, 16'h0000, 16'hFFFF, 16'h1234, 16'h0000, 16'h0000, 0};
        seq[2] = '{0, 1, 6, 16'h0042, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 4, 0, 6, 0, 16'h0000, 16'h0042, 16'h1234, 16'h0000, 16'h0000, 0};
        seq[3] = '{0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 6, 0, 2, 0, 16'h0042, 16'h0000, 16'h1234, 16'h0000, 16'h0000, 0};

        apply(seq[0], 100);
        rst_vec = 16'h1235;
        apply(seq[1], 101);
        apply(seq[2], 102);
        apply(seq[3], 103);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
